// File: rtl/md_unit_pkg.sv
// md_unit shared definitions: op codes, op-class decode, FSM states.
// No ports; imported by md_unit.
package md_unit_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MADD  = 3'd4,
    OP_MADDU = 3'd5,
    OP_MSUB  = 3'd6,
    OP_MSUBU = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Per-op context latched at start.
  typedef struct packed {
    logic [2:0] op;
    logic       neg_res;
    logic       neg_rem;
    logic       dz;
  } md_ctx_t;

  function automatic logic is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  // Even codes are the signed flavours.
  function automatic logic is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_acc(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic is_sub(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

endpackage

// File: rtl/md_div_step.sv
// md_div_step: one combinational restoring-division step.
// Ports: rem_i/quo_i/div_i in (XLEN), rem_o/quo_o out (XLEN).
module md_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] div_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] sh;
  logic [XLEN:0] diff;

  // quo_i carries the unconsumed dividend bits at its top and
  // collects quotient bits at its bottom.
  always_comb begin
    sh   = {rem_i, quo_i[XLEN-1]};
    diff = sh - {1'b0, div_i};
    if (diff[XLEN]) begin
      rem_o = sh[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end else begin
      rem_o = diff[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: iterative multiply/divide (+MADD/MSUB) for the EX stage.
// Ports: clk, rst, start_i, op_i, src_a_i, src_b_i, hi_i, lo_i,
//  flush_i, hi_wr_i, lo_wr_i -> busy_o, done_o, hi_we_o, lo_we_o,
//  hi_o, lo_o, div_zero_o.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] src_a_i,
  input  logic [XLEN-1:0] src_b_i,
  input  logic [XLEN-1:0] hi_i,
  input  logic [XLEN-1:0] lo_i,
  input  logic            flush_i,
  input  logic            hi_wr_i,
  input  logic            lo_wr_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            hi_we_o,
  output logic            lo_we_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o,
  output logic            div_zero_o
);

  localparam int CW = $clog2(XLEN);
  localparam int MUL_N = XLEN / MUL_STEP;
  localparam logic [CW-1:0] MUL_LAST = CW'(MUL_N - 1);
  localparam logic [CW-1:0] DIV_LAST = CW'(XLEN - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  md_ctx_t           ctx_q, ctx_d;
  logic [XLEN-1:0]   opd_q, opd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] add_q, add_d;
  logic              hi_seen_q, hi_seen_d;
  logic              lo_seen_q, lo_seen_d;
  logic [XLEN-1:0]   hi_res_q, hi_res_d;
  logic [XLEN-1:0]   lo_res_q, lo_res_d;
  logic              dz_res_q, dz_res_d;

  logic            go;
  logic            st_div;
  logic            a_neg;
  logic            b_neg;
  logic            b_zero;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic [CW-1:0]   last;

  assign go     = start_i & ~flush_i;
  assign st_div = is_div(op_i);
  assign a_neg  = is_signed(op_i) & src_a_i[XLEN-1];
  assign b_neg  = is_signed(op_i) & src_b_i[XLEN-1];
  assign b_zero = (src_b_i == '0);
  assign mag_a  = a_neg ? -src_a_i : src_a_i;
  assign mag_b  = b_neg ? -src_b_i : src_b_i;
  assign last   = is_div(ctx_q.op) ? DIV_LAST : MUL_LAST;

  // Multiply step: acc = {partial hi, remaining multiplier lo}.
  logic [XLEN+MUL_STEP-1:0] part;
  logic [XLEN+MUL_STEP-1:0] msum;
  logic [2*XLEN-1:0]        mul_nxt;

  always_comb begin
    part = '0;
    for (int j = 0; j < MUL_STEP; j++) begin
      if (acc_q[j]) begin
        part = part + ({{MUL_STEP{1'b0}}, opd_q} << j);
      end
    end
    msum    = part + {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]};
    mul_nxt = {msum, acc_q[XLEN-1:MUL_STEP]};
  end

  // Divide step: acc = {remainder, dividend/quotient}.
  logic [XLEN-1:0] div_rem;
  logic [XLEN-1:0] div_quo;

  md_div_step #(
    .XLEN (XLEN)
  ) u_div_step (
    .rem_i (acc_q[2*XLEN-1:XLEN]),
    .quo_i (acc_q[XLEN-1:0]),
    .div_i (opd_q),
    .rem_o (div_rem),
    .quo_o (div_quo)
  );

  // Sign fix-up and accumulate.
  logic [2*XLEN-1:0] prod_s;
  logic [2*XLEN-1:0] fix_mul;
  logic [XLEN-1:0]   fix_hi;
  logic [XLEN-1:0]   fix_lo;

  always_comb begin
    prod_s  = ctx_q.neg_res ? -acc_q : acc_q;
    fix_mul = prod_s;
    if (is_acc(ctx_q.op)) begin
      fix_mul = is_sub(ctx_q.op) ? (add_q - prod_s)
                                 : (add_q + prod_s);
    end
    fix_hi = fix_mul[2*XLEN-1:XLEN];
    fix_lo = fix_mul[XLEN-1:0];
    if (ctx_q.dz) begin
      fix_hi = acc_q[2*XLEN-1:XLEN];
      fix_lo = acc_q[XLEN-1:0];
    end else if (is_div(ctx_q.op)) begin
      fix_lo = ctx_q.neg_res ? -acc_q[XLEN-1:0]
                             : acc_q[XLEN-1:0];
      fix_hi = ctx_q.neg_rem ? -acc_q[2*XLEN-1:XLEN]
                             : acc_q[2*XLEN-1:XLEN];
    end
  end

  // FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. Flush beats start; start annuls any op.
  always_comb begin
    state_d = state_q;
    if (flush_i) begin
      state_d = ST_IDLE;
    end else if (start_i) begin
      state_d = (st_div && b_zero) ? ST_FIX : ST_CALC;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_CALC: if (cnt_q == last) state_d = ST_FIX;
        ST_FIX:  state_d = ST_DONE;
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs.
  always_comb begin
    busy_o  = (state_q == ST_CALC) || (state_q == ST_FIX);
    done_o  = (state_q == ST_DONE);
    hi_we_o = (state_q == ST_DONE) & ~hi_seen_q;
    lo_we_o = (state_q == ST_DONE) & ~lo_seen_q;
  end

  assign hi_o       = hi_res_q;
  assign lo_o       = lo_res_q;
  assign div_zero_o = dz_res_q;

  // Datapath next values.
  always_comb begin
    cnt_d = cnt_q;
    ctx_d = ctx_q;
    opd_d = opd_q;
    acc_d = acc_q;
    add_d = add_q;
    if (go) begin
      cnt_d         = '0;
      ctx_d.op      = op_i;
      ctx_d.neg_res = a_neg ^ b_neg;
      ctx_d.neg_rem = a_neg;
      ctx_d.dz      = st_div & b_zero;
      add_d         = {hi_i, lo_i};
      if (st_div && b_zero) begin
        opd_d = '0;
        acc_d = {src_a_i, {XLEN{1'b1}}};
      end else if (st_div) begin
        opd_d = mag_b;
        acc_d = {{XLEN{1'b0}}, mag_a};
      end else begin
        opd_d = mag_a;
        acc_d = {{XLEN{1'b0}}, mag_b};
      end
    end else if (state_q == ST_CALC) begin
      cnt_d = cnt_q + CW'(1);
      acc_d = is_div(ctx_q.op) ? {div_rem, div_quo} : mul_nxt;
    end
  end

  // Sticky MTHI/MTLO suppression; start-cycle writes count too.
  always_comb begin
    hi_seen_d = hi_seen_q;
    lo_seen_d = lo_seen_q;
    if (flush_i) begin
      hi_seen_d = 1'b0;
      lo_seen_d = 1'b0;
    end else if (start_i) begin
      hi_seen_d = hi_wr_i;
      lo_seen_d = lo_wr_i;
    end else if (busy_o) begin
      hi_seen_d = hi_seen_q | hi_wr_i;
      lo_seen_d = lo_seen_q | lo_wr_i;
    end
  end

  // Result registers load only on entry to DONE.
  always_comb begin
    hi_res_d = hi_res_q;
    lo_res_d = lo_res_q;
    dz_res_d = dz_res_q;
    if (state_d == ST_DONE && state_q == ST_FIX) begin
      hi_res_d = fix_hi;
      lo_res_d = fix_lo;
      dz_res_d = ctx_q.dz;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      ctx_q     <= '0;
      opd_q     <= '0;
      acc_q     <= '0;
      add_q     <= '0;
      hi_seen_q <= 1'b0;
      lo_seen_q <= 1'b0;
      hi_res_q  <= '0;
      lo_res_q  <= '0;
      dz_res_q  <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      ctx_q     <= ctx_d;
      opd_q     <= opd_d;
      acc_q     <= acc_d;
      add_q     <= add_d;
      hi_seen_q <= hi_seen_d;
      lo_seen_q <= lo_seen_d;
      hi_res_q  <= hi_res_d;
      lo_res_q  <= lo_res_d;
      dz_res_q  <= dz_res_d;
    end
  end

endmodule
